// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider controller and its shift stage.
// The controller FSM encoding and the default operand width live here.
package div_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SHIFT   = 3'd2,
    S_COMPARE = 3'd3,
    S_WRITE   = 3'd4,
    S_FINISH  = 3'd5
  } div_state_t;

endpackage

// File: rtl/div_cmp_sub.sv
// Restoring-division compare/subtract: quotient bit and trial difference.
module div_cmp_sub #(
  parameter int N = 8
) (
  input  logic [N-1:0] rem_in,
  input  logic [N-1:0] divisor,
  output logic         qbit,
  output logic [N-1:0] difference
);

  // unsigned compare; difference wraps mod 2^N and is only used when qbit=1
  always_comb begin
    qbit       = (rem_in >= divisor);
    difference = rem_in - divisor;
  end

endmodule

// File: rtl/div_restore_ctrl.sv
// Restoring divider controller. Sequences an external shift stage that holds
// the dividend and partial remainder, decides one quotient bit per pass and
// writes back the restored/subtracted remainder.
// Optional macro DIV_ZERO_CHECK_EN: divisor 0 short-circuits to FINISH with
// quotient all ones, remainder 0 and div_zero set.
module div_restore_ctrl
  import div_pkg::*;
#(
  parameter int N = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] divisor,
  input  logic [N-1:0] rem_in,
  input  logic         last,
  output logic         shift_load,
  output logic         shift_step,
  output logic         rem_wr,
  output logic [N-1:0] rem_new,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         seq_err,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);

  div_state_t    state, state_nxt;
  logic [N-1:0]  div_r;
  logic [CW-1:0] cnt;
  logic          qbit;
  logic [N-1:0]  diff;
  logic          final_bit;
  logic          dz_start;

  div_cmp_sub #(.N(N)) u_cmp (
    .rem_in     (rem_in),
    .divisor    (div_r),
    .qbit       (qbit),
    .difference (diff)
  );

  // the compare being evaluated is the N-th one (counter not yet bumped)
  assign final_bit = (cnt == CW'(N - 1));

`ifdef DIV_ZERO_CHECK_EN
  assign dz_start = (divisor == '0);
`else
  assign dz_start = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next state and per-state strobes
  always_comb begin
    state_nxt  = state;
    shift_load = 1'b0;
    shift_step = 1'b0;
    rem_wr     = 1'b0;
    busy       = (state != S_IDLE);
    done       = (state == S_FINISH);
    case (state)
      S_IDLE:    if (start) state_nxt = dz_start ? S_FINISH : S_LOAD;
      S_LOAD:    begin shift_load = 1'b1; state_nxt = S_SHIFT; end
      S_SHIFT:   begin shift_step = 1'b1; state_nxt = S_COMPARE; end
      S_COMPARE: begin
        if (qbit)           state_nxt = S_WRITE;
        else if (final_bit) state_nxt = S_FINISH;
        else                state_nxt = S_SHIFT;
      end
      S_WRITE:   begin
        rem_wr    = 1'b1;
        state_nxt = (cnt == CW'(N)) ? S_FINISH : S_SHIFT;
      end
      S_FINISH:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // datapath: operand latch, quotient shift, bit count, result capture, status
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      rem_new   <= '0;
      seq_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          div_r     <= divisor;
          cnt       <= '0;
          quotient  <= dz_start ? '1 : '0;
          remainder <= '0;
          rem_new   <= '0;
          seq_err   <= 1'b0;
        end
        S_COMPARE: begin
          quotient <= {quotient[N-2:0], qbit};
          cnt      <= cnt + CW'(1);
          if (qbit) rem_new <= diff;
          // shift stage must report exhaustion exactly on the final bit
          if (final_bit ? !last : last) seq_err <= 1'b1;
          if (!qbit && final_bit) remainder <= rem_in;
        end
        S_WRITE: if (cnt == CW'(N)) remainder <= rem_new;
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  // divide-by-zero flag, held with the result until the next accepted start
  always_ff @(posedge clk) begin
    if (rst)                          div_zero <= 1'b0;
    else if (state == S_IDLE && start) div_zero <= dz_start;
  end
`else
  assign div_zero = 1'b0;
`endif

endmodule
